if_id_queue: RTL and testbench

// - Parametrised IF/ID boundary: a DEPTH-entry in-order queue of fetched
//   {instr, pc, exc, bd} entries, between fetch and decode.
// - Replaces the single IF/ID register. Fetch can keep filling while decode stalls.
// - Flush clears the queue. An interrupt request replaces its contents with one

---
 rtl/if_id_queue.sv | 106 ++++++++++
 tb/tb_if_id_queue.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/if_id_queue.sv
// IF/ID boundary queue: DEPTH-entry in-order FIFO of fetched {instr, pc, exc, bd}
// entries between fetch and decode, with flush and interrupt-bubble injection.
module if_id_queue #(
  parameter int                 DATA_W     = 32,
  parameter int                 EXC_W      = 5,
  parameter int                 DEPTH      = 2,
  parameter logic [DATA_W-1:0]  HANDLER_PC = 32'h0000_4180,
  parameter int                 CNT_W      = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              f_valid,
  output logic              f_ready,
  input  logic [DATA_W-1:0] f_instr,
  input  logic [DATA_W-1:0] f_pc,
  input  logic [EXC_W-1:0]  f_exc,
  input  logic              f_bd,
  input  logic              d_ready,
  output logic              d_valid,
  output logic [DATA_W-1:0] d_instr,
  output logic [DATA_W-1:0] d_pc,
  output logic [EXC_W-1:0]  d_exc,
  output logic              d_bd,
  input  logic              flush,
  input  logic              int_req,
  output logic [CNT_W-1:0]  count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0]  rd_ptr_reg, rd_ptr_next;
  logic [PTR_W-1:0]  wr_ptr_reg, wr_ptr_next;
  logic [CNT_W-1:0]  count_reg, count_next;
  logic              full, empty, push, pop;

  logic [DATA_W-1:0] instr_mem [DEPTH];
  logic [DATA_W-1:0] pc_mem    [DEPTH];
  logic [EXC_W-1:0]  exc_mem   [DEPTH];
  logic              bd_mem    [DEPTH];

  // Ready comes from registered occupancy only, so a full queue refuses a
  // push even when decode pops in the same cycle.
  assign full    = (count_reg == CNT_W'(DEPTH));
  assign empty   = (count_reg == '0);
  assign f_ready = ~full;
  assign d_valid = ~empty;
  assign push    = f_valid & ~full & ~flush & ~int_req;
  assign pop     = ~empty & d_ready;
  assign count   = count_reg;

  always_comb begin
    rd_ptr_next = rd_ptr_reg;
    wr_ptr_next = wr_ptr_reg;
    count_next  = count_reg;
    if (int_req) begin
      // The bubble always lands in slot 0, leaving exactly one entry.
      rd_ptr_next = '0;
      wr_ptr_next = PTR_W'(1);
      count_next  = CNT_W'(1);
    end else if (flush) begin
      rd_ptr_next = '0;
      wr_ptr_next = '0;
      count_next  = '0;
    end else begin
      if (push) wr_ptr_next = wr_ptr_reg + PTR_W'(1);
      if (pop)  rd_ptr_next = rd_ptr_reg + PTR_W'(1);
      if (push && !pop)      count_next = count_reg + CNT_W'(1);
      else if (pop && !push) count_next = count_reg - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      rd_ptr_reg <= rd_ptr_next;
      wr_ptr_reg <= wr_ptr_next;
      count_reg  <= count_next;
    end
  end

  // Storage is never reset; emptiness is handled by gating the outputs.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
    always_ff @(posedge clk) begin
      if (int_req && gi == 0) begin
        instr_mem[gi] <= '0;
        pc_mem[gi]    <= HANDLER_PC;
        exc_mem[gi]   <= '0;
        bd_mem[gi]    <= 1'b0;
      end else if (push && wr_ptr_reg == PTR_W'(gi)) begin
        instr_mem[gi] <= f_instr;
        pc_mem[gi]    <= f_pc;
        exc_mem[gi]   <= f_exc;
        bd_mem[gi]    <= f_bd;
      end
    end
  end

  assign d_instr = empty ? '0   : instr_mem[rd_ptr_reg];
  assign d_pc    = empty ? '0   : pc_mem[rd_ptr_reg];
  assign d_exc   = empty ? '0   : exc_mem[rd_ptr_reg];
  assign d_bd    = empty ? 1'b0 : bd_mem[rd_ptr_reg];

endmodule

// File: tb/tb_if_id_queue.sv
// Bench for if_id_queue: directed scenarios then random traffic, all checked
// against a queue-based reference model of the fetch/decode boundary.
module tb_if_id_queue;
  localparam int DATA_W = 32;
  localparam int EXC_W  = 5;
  localparam int DEPTH  = 2;
  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam logic [31:0] HPC = 32'h0000_4180;

  logic              clk = 1'b0;
  logic              reset;
  logic              f_valid, f_ready;
  logic [DATA_W-1:0] f_instr, f_pc;
  logic [EXC_W-1:0]  f_exc;
  logic              f_bd;
  logic              d_ready, d_valid;
  logic [DATA_W-1:0] d_instr, d_pc;
  logic [EXC_W-1:0]  d_exc;
  logic              d_bd;
  logic              flush, int_req;
  logic [CNT_W-1:0]  count;

  if_id_queue #(
    .DATA_W(DATA_W), .EXC_W(EXC_W), .DEPTH(DEPTH), .HANDLER_PC(HPC), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset),
    .f_valid(f_valid), .f_ready(f_ready), .f_instr(f_instr), .f_pc(f_pc),
    .f_exc(f_exc), .f_bd(f_bd),
    .d_ready(d_ready), .d_valid(d_valid), .d_instr(d_instr), .d_pc(d_pc),
    .d_exc(d_exc), .d_bd(d_bd),
    .flush(flush), .int_req(int_req), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [4:0]  exc;
    logic        bd;
  } ent_t;

  ent_t mq[$];
  int vectors = 0;
  int miscompares = 0;
  int step_no = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare every output against what the model says the queue holds now.
  task automatic check_model();
    ent_t h;
    if (mq.size() == 0) begin
      h.instr = '0; h.pc = '0; h.exc = '0; h.bd = 1'b0;
    end else begin
      h = mq[0];
    end
    chk("d_valid", 64'(d_valid), 64'(mq.size() != 0));
    chk("d_instr", 64'(d_instr), 64'(h.instr));
    chk("d_pc",    64'(d_pc),    64'(h.pc));
    chk("d_exc",   64'(d_exc),   64'(h.exc));
    chk("d_bd",    64'(d_bd),    64'(h.bd));
    chk("count",   64'(count),   64'(mq.size()));
    chk("f_ready", 64'(f_ready), 64'(mq.size() < DEPTH));
  endtask

  task automatic step(input logic fv, input logic [31:0] ins, input logic [31:0] pc,
                      input logic [4:0] ex, input logic b, input logic dr,
                      input logic fl, input logic ir, input logic rs);
    ent_t e;
    bit   do_pop, do_push;
    f_valid = fv; f_instr = ins; f_pc = pc; f_exc = ex; f_bd = b;
    d_ready = dr; flush = fl; int_req = ir; reset = rs;
    #1;
    check_model();
    $display("step %0d: fv=%0b pc=%h dr=%0b fl=%0b ir=%0b rs=%0b | d_valid=%0b d_pc=%h count=%0d",
             step_no, fv, pc, dr, fl, ir, rs, d_valid, d_pc, count);
    step_no++;
    if (rs) begin
      mq.delete();
    end else if (ir) begin
      mq.delete();
      e.instr = '0; e.pc = HPC; e.exc = '0; e.bd = 1'b0;
      mq.push_back(e);
    end else if (fl) begin
      mq.delete();
    end else begin
      do_pop  = (mq.size() != 0) && dr;
      do_push = fv && (mq.size() < DEPTH);
      if (do_pop) void'(mq.pop_front());
      if (do_push) begin
        e.instr = ins; e.pc = pc; e.exc = ex; e.bd = b;
        mq.push_back(e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic dr);
    step(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, dr, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic push1(input logic [31:0] ins, input logic [31:0] pc, input logic dr);
    step(1'b1, ins, pc, 5'd0, 1'b0, dr, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    f_valid = 0; f_instr = 0; f_pc = 0; f_exc = 0; f_bd = 0;
    d_ready = 0; flush = 0; int_req = 0; reset = 1;
    @(posedge clk); #1;
    step(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Single push into empty queue shows up next cycle.
    push1(32'h3C01_1234, 32'h0000_3000, 1'b1);
    chk("t1_instr", 64'(d_instr), 64'h3C01_1234);
    chk("t1_pc",    64'(d_pc),    64'h3000);
    chk("t1_count", 64'(count),   64'd1);
    idle(1'b1);

    // Decode stalled: third push is refused, then drain in order.
    push1(32'h1111_0000, 32'h3000, 1'b0);
    push1(32'h1111_0004, 32'h3004, 1'b0);
    chk("t2_fready", 64'(f_ready), 64'd0);
    push1(32'h1111_0008, 32'h3008, 1'b0);
    chk("t2_head", 64'(d_pc), 64'h3000);
    idle(1'b1);
    chk("t2_second", 64'(d_pc), 64'h3004);
    idle(1'b1);
    chk("t2_empty", 64'(d_valid), 64'd0);

    // Full queue: pop and push in the same cycle, push refused.
    push1(32'hA, 32'h3100, 1'b0);
    push1(32'hB, 32'h3104, 1'b0);
    push1(32'hC, 32'h3108, 1'b1);
    chk("t3_count", 64'(count), 64'd1);
    chk("t3_pc",    64'(d_pc),  64'h3104);

    // Interrupt with a full queue and a pending fetch.
    push1(32'hD, 32'h310C, 1'b0);
    step(1'b1, 32'hE, 32'h3110, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("t4_pc",    64'(d_pc),    64'(HPC));
    chk("t4_count", 64'(count),   64'd1);
    // Repeated interrupt reloads the bubble.
    step(1'b1, 32'hF, 32'h3114, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("t4_reload", 64'(count),  64'd1);

    // flush+int_req: bubble wins; then flush alone empties.
    push1(32'h10, 32'h3200, 1'b0);
    step(1'b1, 32'h11, 32'h3204, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("t5_bubble", 64'(d_pc), 64'(HPC));
    step(1'b1, 32'h12, 32'h3208, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("t5_flush", 64'(count), 64'd0);

    // Exception/bd fields survive pointer wrap-around.
    step(1'b1, 32'h20, 32'h3011, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t6_exc", 64'(d_exc), 64'd4);
    chk("t6_bd",  64'(d_bd),  64'd1);
    for (int i = 0; i < 5; i++)
      step(1'b1, 32'h21 + i, 32'h3014 + 4 * i, 5'(i), i[0], 1'b1, 1'b0, 1'b0, 1'b0);
    idle(1'b1);
    idle(1'b1);

    // Random traffic against the model, including occasional reset.
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 9) < 7), $urandom, $urandom, 5'($urandom), 1'($urandom),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 19) == 0),
           1'($urandom_range(0, 24) == 0), 1'($urandom_range(0, 99) == 0));
    end
    idle(1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
